caesar_stream_cipher: RTL and testbench

Parametrised streaming Caesar cipher that substitutes LANES ASCII characters per beat. It sits between a byte-stream source and sink, using valid/ready handshakes on input and output. A separate key handshake loads the shift, and keys are only ever applied at frame boundaries. A two-stage pipeline sustains one beat per cycle under backpressure and reports invalid keys and characters.

---
 rtl/caesar_pkg.sv | 35 +++
 rtl/caesar_stream_cipher_lane.sv | 78 +++++++
 rtl/caesar_stream_cipher.sv | 137 +++++++++++++
 tb/tb_caesar_stream_cipher.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/caesar_pkg.sv
// Shared constants, FSM state type and character classifier for the
// streaming Caesar cipher.
package caesar_pkg;

    localparam logic [7:0] UPPER_A   = 8'h41;
    localparam logic [7:0] UPPER_Z   = 8'h5A;
    localparam logic [7:0] LOWER_A   = 8'h61;
    localparam logic [7:0] LOWER_Z   = 8'h7A;
    localparam logic [7:0] NULL_CHAR = 8'h00;
    localparam logic [5:0] ALPHA_LEN = 6'd26;
    localparam logic [4:0] KEY_MAX   = 5'd26;

    typedef enum logic [1:0] {
        NO_KEY   = 2'd0,
        IDLE     = 2'd1,
        IN_FRAME = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CLS_UPPER = 2'd0,
        CLS_LOWER = 2'd1,
        CLS_OTHER = 2'd2
    } char_class_e;

    function automatic char_class_e classify(input logic [7:0] c);
        if (c >= UPPER_A && c <= UPPER_Z) begin
            return CLS_UPPER;
        end else if (c >= LOWER_A && c <= LOWER_Z) begin
            return CLS_LOWER;
        end else begin
            return CLS_OTHER;
        end
    endfunction

endpackage

// File: rtl/caesar_stream_cipher_lane.sv
// One character lane: stage 1 classifies and adds the key, stage 2 wraps
// the sum into the alphabet and forms the output character.
module caesar_lane
    import caesar_pkg::*;
#(
    parameter bit PASS_NONLETTER = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s1_en_i,
    input  logic       s2_en_i,
    input  logic [4:0] k_eff_i,
    input  logic [7:0] char_i,
    output logic [7:0] char_o,
    output logic       err_o
);

    char_class_e cls_s;
    logic [4:0]  idx_s;
    logic [5:0]  r_s;
    logic [7:0]  base_q, base_d, raw_q, raw_d, out_q, out_d;
    logic [5:0]  sum_q, sum_d;
    logic        other_q, other_d, err_q, err_d;

    // Stage-1 and stage-2 next values
    always_comb begin
        cls_s   = classify(char_i);
        // Both letter ranges start at xxx0_0001, so the low five bits minus one is the index
        idx_s   = char_i[4:0] - 5'd1;
        raw_d   = char_i;
        other_d = 1'b0;
        sum_d   = {1'b0, idx_s} + {1'b0, k_eff_i};
        case (cls_s)
            CLS_UPPER: base_d = UPPER_A;
            CLS_LOWER: base_d = LOWER_A;
            default: begin
                base_d  = NULL_CHAR;
                other_d = 1'b1;
                sum_d   = 6'd0;
            end
        endcase

        r_s   = (sum_q >= ALPHA_LEN) ? (sum_q - ALPHA_LEN) : sum_q;
        err_d = other_q;
        if (other_q) begin
            out_d = PASS_NONLETTER ? raw_q : NULL_CHAR;
        end else begin
            out_d = base_q + {2'b00, r_s};
        end
    end

    // Pipeline registers, each stage loads only on its shared enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= 8'h00;
            raw_q   <= 8'h00;
            sum_q   <= 6'd0;
            other_q <= 1'b0;
            out_q   <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            if (s1_en_i) begin
                base_q  <= base_d;
                raw_q   <= raw_d;
                sum_q   <= sum_d;
                other_q <= other_d;
            end
            if (s2_en_i) begin
                out_q <= out_d;
                err_q <= err_d;
            end
        end
    end

    assign char_o = out_q;
    assign err_o  = err_q;

endmodule

// File: rtl/caesar_stream_cipher.sv
// Streaming Caesar cipher top: key register, frame FSM, two-stage
// valid/last pipeline and handshakes around LANES caesar_lane instances.
module caesar_stream_cipher
    import caesar_pkg::*;
#(
    parameter int LANES          = 4,
    parameter bit PASS_NONLETTER = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_valid_i,
    output logic               key_ready_o,
    input  logic               key_dir_i,
    input  logic [4:0]         key_shift_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    input  logic [8*LANES-1:0] s_data_i,
    input  logic               s_last_i,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic [8*LANES-1:0] m_data_o,
    output logic               m_last_o,
    output logic [LANES-1:0]   m_err_char_o,
    output logic               err_key_o
);

    state_e     state_q, state_d;
    logic [4:0] k_eff_q, k_eff_d, k_raw_s;
    logic       err_key_q, err_key_d;
    logic       v1_q, v1_d, v2_q, v2_d, last1_q, last1_d, last2_q, last2_d;
    logic       key_fire_s, key_legal_s, s_fire_s, adv2_s, s1_free_s;

    // Handshakes: a key may only load with an empty pipeline outside a frame
    always_comb begin
        case (state_q)
            NO_KEY:  key_ready_o = 1'b1;
            IDLE:    key_ready_o = !v1_q && !v2_q;
            default: key_ready_o = 1'b0;
        endcase
        key_legal_s = (key_shift_i <= KEY_MAX);
        key_fire_s  = key_valid_i && key_ready_o;
        adv2_s      = v1_q && (!v2_q || m_ready_i);
        s1_free_s   = !v1_q || adv2_s;
        s_ready_o   = (state_q != NO_KEY) && !key_fire_s && s1_free_s;
        s_fire_s    = s_valid_i && s_ready_o;
    end

    // Key register, sticky key error and frame FSM next state
    always_comb begin
        state_d   = state_q;
        k_eff_d   = k_eff_q;
        err_key_d = err_key_q;
        k_raw_s   = key_dir_i ? (KEY_MAX - key_shift_i) : key_shift_i;
        if (key_fire_s) begin
            if (key_legal_s) begin
                err_key_d = 1'b0;
                k_eff_d   = (k_raw_s == KEY_MAX) ? 5'd0 : k_raw_s;
                state_d   = (state_q == NO_KEY) ? IDLE : state_q;
            end else begin
                err_key_d = 1'b1;
            end
        end else if (s_fire_s) begin
            case (state_q)
                IDLE:     state_d = s_last_i ? IDLE : IN_FRAME;
                IN_FRAME: state_d = s_last_i ? IDLE : IN_FRAME;
                default:  state_d = state_q;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Valid/last pipeline next state
    always_comb begin
        v1_d    = v1_q;
        last1_d = last1_q;
        v2_d    = v2_q;
        last2_d = last2_q;
        if (s_fire_s) begin
            v1_d    = 1'b1;
            last1_d = s_last_i;
        end else if (adv2_s) begin
            v1_d = 1'b0;
        end else begin
            v1_d = v1_q;
        end
        if (adv2_s) begin
            v2_d    = 1'b1;
            last2_d = last1_q;
        end else if (m_ready_i) begin
            v2_d = 1'b0;
        end else begin
            v2_d = v2_q;
        end
    end

    // Control and pipeline-valid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= NO_KEY;
            k_eff_q   <= 5'd0;
            err_key_q <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            last1_q   <= 1'b0;
            last2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_eff_q   <= k_eff_d;
            err_key_q <= err_key_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            last1_q   <= last1_d;
            last2_q   <= last2_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        caesar_lane #(
            .PASS_NONLETTER(PASS_NONLETTER)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .s1_en_i (s_fire_s),
            .s2_en_i (adv2_s),
            .k_eff_i (k_eff_q),
            .char_i  (s_data_i[8*i +: 8]),
            .char_o  (m_data_o[8*i +: 8]),
            .err_o   (m_err_char_o[i])
        );
    end

    assign m_valid_o = v2_q;
    assign m_last_o  = last2_q;
    assign err_key_o = err_key_q;

endmodule

// File: tb/tb_caesar_stream_cipher.sv
// Self-checking bench: directed frames against a behavioural Caesar model,
// two DUT copies (pass-through and nulled non-letters) share all stimulus.
module tb_caesar_stream_cipher;

    localparam int LANES = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0, key_dir = 1'b0;
    logic [4:0]  key_shift = 5'd0;
    logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
    logic [31:0] s_data = 32'h0;

    logic        key_ready, s_ready, m_valid, m_last, err_key;
    logic [31:0] m_data;
    logic [3:0]  m_err;
    logic        key_ready0, s_ready0, m_valid0, m_last0, err_key0;
    logic [31:0] m_data0;
    logic [3:0]  m_err0;

    always #5 clk = ~clk;

    caesar_stream_cipher #(.LANES(LANES), .PASS_NONLETTER(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid_i(key_valid), .key_ready_o(key_ready), .key_dir_i(key_dir), .key_shift_i(key_shift),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_last_i(s_last),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
        .m_err_char_o(m_err), .err_key_o(err_key));

    caesar_stream_cipher #(.LANES(LANES), .PASS_NONLETTER(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .key_valid_i(key_valid), .key_ready_o(key_ready0), .key_dir_i(key_dir), .key_shift_i(key_shift),
        .s_valid_i(s_valid), .s_ready_o(s_ready0), .s_data_i(s_data), .s_last_i(s_last),
        .m_valid_o(m_valid0), .m_ready_i(m_ready), .m_data_o(m_data0), .m_last_o(m_last0),
        .m_err_char_o(m_err0), .err_key_o(err_key0));

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d0;
        logic [3:0]  err;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    mdl_off = 0;
    logic  mdl_err = 1'b0;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Plain modular arithmetic on the signed shift, one character at a time
    function automatic beat_t model(input logic [31:0] d, input logic last);
        beat_t b;
        b.d1 = '0; b.d0 = '0; b.err = '0; b.last = last;
        for (int i = 0; i < LANES; i++) begin
            int c, base, r;
            c = int'(d[8*i +: 8]);
            if (c >= 65 && c <= 90) base = 65;
            else if (c >= 97 && c <= 122) base = 97;
            else base = -1;
            if (base < 0) begin
                b.d1[8*i +: 8] = d[8*i +: 8];
                b.err[i] = 1'b1;
            end else begin
                r = ((c - base + mdl_off) % 26 + 26) % 26;
                b.d1[8*i +: 8] = 8'(base + r);
                b.d0[8*i +: 8] = 8'(base + r);
            end
        end
        return b;
    endfunction

    // Scoreboard bookkeeping on every accepted key, input beat and output beat
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            mdl_err <= 1'b0;
        end else begin
            if (s_valid && s_ready) exp_q.push_back(model(s_data, s_last));
            if (m_valid && m_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (key_valid && key_ready) begin
                if (key_shift > 5'd26) begin
                    mdl_err <= 1'b1;
                end else begin
                    mdl_err <= 1'b0;
                    mdl_off <= key_dir ? -int'(key_shift) : int'(key_shift);
                end
            end
        end
    end

    // Compare process: every cycle out of reset, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("err_key", err_key, mdl_err);
            chk("err_key_p0", err_key0, mdl_err);
            chk("m_valid_pair", m_valid0, m_valid);
            chk("key_ready_pair", key_ready0, key_ready);
            chk("s_ready_pair", s_ready0, s_ready);
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %h with no beat expected", m_data);
                end else begin
                    chk("m_data", m_data, exp_q[0].d1);
                    chk("m_data_p0", m_data0, exp_q[0].d0);
                    chk("m_err_char", m_err, exp_q[0].err);
                    chk("m_err_char_p0", m_err0, exp_q[0].err);
                    chk("m_last", m_last, exp_q[0].last);
                    chk("m_last_p0", m_last0, exp_q[0].last);
                end
            end
        end
    end

    task automatic load_key(input logic dir, input logic [4:0] sh);
        int n = 0;
        key_valid = 1'b1; key_dir = dir; key_shift = sh;
        #1;
        while (!key_ready && n < 50) begin @(negedge clk); #1; n++; end
        if (!key_ready) begin
            checks++; errors++;
            $display("FAIL key_timeout: got key_ready 0 expected 1 within 50 cycles");
        end
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last, output int waits);
        waits = 0;
        s_valid = 1'b1; s_data = d; s_last = last;
        #1;
        while (!s_ready && waits < 50) begin @(negedge clk); #1; waits++; end
        if (!s_ready) begin
            checks++; errors++;
            $display("FAIL s_ready_timeout: got s_ready 0 expected 1 within 50 cycles");
        end
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [31:0] d1, input logic [31:0] d0,
                              input logic [3:0] err);
        int n = 0;
        while (!m_valid && n < 50) begin @(negedge clk); n++; end
        chk({name, "_valid"}, m_valid, 1'b1);
        chk({name, "_data"}, m_data, d1);
        chk({name, "_data_p0"}, m_data0, d0);
        chk({name, "_err"}, m_err, err);
        chk({name, "_last"}, m_last, 1'b1);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("drain_empty", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [3:0] pat;
        pat = 4'b1001;
        s_valid = 1'b1; s_data = 32'h64636261;
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_key_ready", key_ready, 1'b1);
        chk("no_key_s_ready", s_ready, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 32'h0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_m_err", m_err, 4'h0);
        chk("rst_err_key", err_key, 1'b0);
        s_valid = 1'b0;
        @(negedge clk);

        // Right 3, "abcZ" -> "defC", output two cycles after acceptance
        load_key(1'b0, 5'd3);
        send_beat(32'h5A636261, 1'b1, w);
        s_valid = 1'b0;
        chk("lat_t1", m_valid, 1'b0);
        @(negedge clk);
        chk("lat_t2", m_valid, 1'b1);
        expect_out("right3", 32'h43666564, 32'h43666564, 4'b0000);

        // Left 1, "aAzZ" -> "zZyY"
        load_key(1'b1, 5'd1);
        send_beat(32'h5A7A4161, 1'b1, w); s_valid = 1'b0;
        expect_out("left1", 32'h59795A7A, 32'h59795A7A, 4'b0000);

        // Shift 26 and shift 0 are identity
        load_key(1'b0, 5'd26);
        send_beat(32'h6C6C6548, 1'b1, w); s_valid = 1'b0;
        expect_out("right26", 32'h6C6C6548, 32'h6C6C6548, 4'b0000);
        load_key(1'b0, 5'd0);
        send_beat(32'h6C6C6548, 1'b1, w); s_valid = 1'b0;
        expect_out("right0", 32'h6C6C6548, 32'h6C6C6548, 4'b0000);

        // Non-letters: forwarded on one copy, nulled on the other
        load_key(1'b0, 5'd1);
        send_beat(32'h205B3161, 1'b1, w); s_valid = 1'b0;
        expect_out("nonletter", 32'h205B3162, 32'h00000062, 4'b1110);

        // Illegal key keeps the previous shift and sets err_key
        load_key(1'b0, 5'd2);
        load_key(1'b0, 5'd27);
        chk("err_key_set", err_key, 1'b1);
        send_beat(32'h64636261, 1'b1, w); s_valid = 1'b0;
        expect_out("after_bad_key", 32'h66656463, 32'h66656463, 4'b0000);
        load_key(1'b1, 5'd4);
        chk("err_key_clear", err_key, 1'b0);

        // Three-beat frame under a 1,0,0,1 backpressure pattern
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    m_ready = pat[i % 4];
                    @(negedge clk);
                end
            end
            begin
                send_beat(32'h44434241, 1'b0, w);
                send_beat(32'h48474645, 1'b0, w);
                send_beat(32'h4C4B4A49, 1'b1, w);
                s_valid = 1'b0;
            end
        join
        m_ready = 1'b1;
        drain();

        // Back-to-back frames with m_ready high: no bubbles
        for (int i = 0; i < 4; i++) begin
            send_beat(32'h61626364 + i, (i % 2) == 1, w);
            chk("no_bubble", w, 0);
        end
        s_valid = 1'b0;
        drain();

        // Key held during a frame waits for the frame to drain
        send_beat(32'h64636261, 1'b0, w); s_valid = 1'b0;
        key_valid = 1'b1; key_dir = 1'b0; key_shift = 5'd5;
        for (int i = 0; i < 3; i++) begin
            #1 chk("key_ready_in_frame", key_ready, 1'b0);
            @(negedge clk);
        end
        send_beat(32'h68676665, 1'b1, w); s_valid = 1'b0;
        #1 chk("key_ready_draining", key_ready, 1'b0);
        load_key(1'b0, 5'd5);
        send_beat(32'h64636261, 1'b1, w); s_valid = 1'b0;
        expect_out("new_key_frame", 32'h69686766, 32'h69686766, 4'b0000);

        // Reset with beats in flight discards them and forgets the key
        m_ready = 1'b0;
        send_beat(32'h64636261, 1'b0, w);
        send_beat(32'h64636261, 1'b0, w);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid, 1'b0);
        chk("midrst_key_ready", key_ready, 1'b1);
        chk("midrst_s_ready", s_ready, 1'b0);
        chk("midrst_m_data", m_data, 32'h0);
        @(negedge clk); #2 rst_n = 1'b1;
        m_ready = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_s_ready", s_ready, 1'b0);
        s_valid = 1'b0;
        @(negedge clk);
        load_key(1'b0, 5'd1);
        send_beat(32'h64636261, 1'b1, w); s_valid = 1'b0;
        expect_out("post_rst_frame", 32'h65646362, 32'h65646362, 4'b0000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
